// File: rtl/rf_pkg.sv
// Shared widths and types for the integer register file and its scoreboard.
package rf_pkg;

  localparam int DATA_W = 64;
  localparam int NREG   = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t ZERO_REG = '0;

  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == ZERO_REG;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending tracker: flags RAW/WAW hazards against in-flight writebacks.
module reg_scoreboard
  import rf_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic            issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic            reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  output logic            stall,
  output logic [NREG-1:0] pending
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic            haz1;
  logic            haz2;
  logic            hazw;

  // A writeback landing this cycle is bypassed, so it never causes a stall.
  function automatic logic hazard(input logic used, input reg_idx_t idx,
                                  input logic [NREG-1:0] pend,
                                  input logic wr, input reg_idx_t wr_idx);
    return used && !is_zero_reg(idx) && pend[idx] && !(wr && wr_idx == idx);
  endfunction

  always_comb begin
    haz1  = hazard(rs1_used, rs1, pending_q, reg_write, write_reg);
    haz2  = hazard(rs2_used, rs2, pending_q, reg_write, write_reg);
    hazw  = hazard(1'b1, issue_rd, pending_q, reg_write, write_reg);
    stall = reset_n && issue_valid && (haz1 || haz2 || hazw);
  end

  // Clear first, then set, so a same-edge issue to the written index stays pending.
  always_comb begin
    pending_d = pending_q;
    if (reg_write && !is_zero_reg(write_reg))
      pending_d[write_reg] = 1'b0;
    if (issue_valid && !stall && !is_zero_reg(issue_rd))
      pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/reg_file_sb.sv
// 64-bit integer register file with write-first bypass reads and a pending scoreboard.
module reg_file_sb
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic              stall,
  output logic [NREG-1:0]   pending
);

  if (NREG != (1 << ADDR_W)) begin : g_bad_params
    $error("reg_file_sb: NREG must equal 2**ADDR_W");
  end

  word_t regs_q [NREG];

  function automatic word_t bypass_read(input logic rst_n, input reg_idx_t idx,
                                        input logic wr, input reg_idx_t wr_idx,
                                        input word_t wr_data, input word_t stored);
    if (!rst_n || is_zero_reg(idx)) return '0;
    if (wr && wr_idx == idx)        return wr_data;
    return stored;
  endfunction

  always_comb begin
    read_data1 = bypass_read(reset_n, rs1, reg_write, write_reg, write_data, regs_q[rs1]);
    read_data2 = bypass_read(reset_n, rs2, reg_write, write_reg, write_data, regs_q[rs2]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      regs_q <= '{default: '0};
    else if (reg_write && !is_zero_reg(write_reg))
      regs_q[write_reg] <= write_data;
  end

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .stall       (stall),
    .pending     (pending)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, x0, bypass, RAW/WAW scoreboard, mid-flight reset.
module tb_reg_file_sb;
  import rf_pkg::*;

  logic              clk;
  logic              reset_n;
  logic [ADDR_W-1:0] rs1, rs2, write_reg, issue_rd;
  logic [DATA_W-1:0] read_data1, read_data2, write_data;
  logic              reg_write, issue_valid, rs1_used, rs2_used, stall;
  logic [NREG-1:0]   pending;

  int checks = 0;
  int errors = 0;

  reg_file_sb dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rs1         (rs1),
    .rs2         (rs2),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .stall       (stall),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    reg_write = 0; write_reg = 0; write_data = '0;
    issue_valid = 0; issue_rd = 0; rs1_used = 0; rs2_used = 0;
    rs1 = 0; rs2 = 0;
  endtask

  // Commit at the next rising edge, then move 1 time unit past it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 0; idle(); tick(); reset_n = 1; #1;
    checks++; if (pending !== '0) begin errors++; $display("FAIL por_pending got %h exp 0", pending); end
    reg_write = 1; write_reg = 5; write_data = 64'hAAAA; tick();
    idle(); rs1 = 5; #1;
    checks++; if (read_data1 !== 64'hAAAA) begin errors++; $display("FAIL reset_pre_x5 got %h exp aaaa", read_data1); end
    reset_n = 0; issue_valid = 1; issue_rd = 5; #1;
    checks++; if (read_data1 !== '0) begin errors++; $display("FAIL reset_read_during got %h exp 0", read_data1); end
    tick(); reset_n = 1; idle(); rs1 = 5; #1;
    checks++; if (read_data1 !== '0) begin errors++; $display("FAIL reset_x5 got %h exp 0", read_data1); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending got %h exp 0", pending); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
  endtask

  task automatic test_x0();
    idle(); reg_write = 1; write_reg = 0; write_data = 64'hFFFF_FFFF_FFFF_FFFF; rs1 = 0; #1;
    checks++; if (read_data1 !== '0) begin errors++; $display("FAIL x0_bypass got %h exp 0", read_data1); end
    tick(); idle(); rs1 = 0; #1;
    checks++; if (read_data1 !== '0) begin errors++; $display("FAIL x0_after got %h exp 0", read_data1); end
    checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL x0_pending got %b exp 0", pending[0]); end
    issue_valid = 1; issue_rd = 0; tick(); idle(); #1;
    checks++; if (pending !== '0) begin errors++; $display("FAIL x0_issue_pending got %h exp 0", pending); end
  endtask

  task automatic test_bypass();
    idle(); reg_write = 1; write_reg = 7; write_data = 64'h10; tick();
    idle(); rs2 = 7; #1;
    checks++; if (read_data2 !== 64'h10) begin errors++; $display("FAIL byp_old got %h exp 10", read_data2); end
    reg_write = 1; write_reg = 7; write_data = 64'h8000_0000_0000_0000; #1;
    checks++; if (read_data2 !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL byp_comb got %h exp 8000000000000000", read_data2); end
    checks++; if (read_data1 !== '0) begin errors++; $display("FAIL byp_other_port got %h exp 0", read_data1); end
    tick(); idle(); rs2 = 7; #1;
    checks++; if (read_data2 !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL byp_after got %h exp 8000000000000000", read_data2); end
  endtask

  task automatic test_raw();
    idle(); issue_valid = 1; issue_rd = 3; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_first_issue stall got %b exp 0", stall); end
    tick(); idle(); #1;
    checks++; if (pending !== 32'h0000_0008) begin errors++; $display("FAIL raw_pending3 got %h exp 8", pending); end
    issue_valid = 1; issue_rd = 10; rs1 = 3; rs1_used = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall cyc%0d got %b exp 1", i, stall); end
      tick();
    end
    checks++; if (pending !== 32'h0000_0008) begin errors++; $display("FAIL raw_held_pending got %h exp 8", pending); end
    reg_write = 1; write_reg = 3; write_data = 64'h1234_5678_9ABC_DEF0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_wb_stall got %b exp 0", stall); end
    checks++; if (read_data1 !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL raw_wb_data got %h exp 123456789abcdef0", read_data1); end
    tick(); idle(); #1;
    checks++; if (pending !== 32'h0000_0400) begin errors++; $display("FAIL raw_pending_after got %h exp 400", pending); end
    issue_valid = 1; issue_rd = 11; rs2 = 10; rs2_used = 1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_rs2_stall got %b exp 1", stall); end
    rs2_used = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_rs2_unused got %b exp 0", stall); end
    idle(); reg_write = 1; write_reg = 10; write_data = 64'h5; tick(); idle(); #1;
    checks++; if (pending !== '0) begin errors++; $display("FAIL raw_cleanup got %h exp 0", pending); end
  endtask

  task automatic test_waw();
    idle(); issue_valid = 1; issue_rd = 9; tick(); idle(); #1;
    checks++; if (pending !== 32'h0000_0200) begin errors++; $display("FAIL waw_set got %h exp 200", pending); end
    issue_valid = 1; issue_rd = 9; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall got %b exp 1", stall); end
    reg_write = 1; write_reg = 9; write_data = 64'h99; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_simul_stall got %b exp 0", stall); end
    tick(); idle(); rs1 = 9; #1;
    checks++; if (pending !== 32'h0000_0200) begin errors++; $display("FAIL waw_set_wins got %h exp 200", pending); end
    checks++; if (read_data1 !== 64'h99) begin errors++; $display("FAIL waw_data got %h exp 99", read_data1); end
    reg_write = 1; write_reg = 20; write_data = 64'h2020; tick(); idle(); rs2 = 20; #1;
    checks++; if (pending !== 32'h0000_0200) begin errors++; $display("FAIL nonpend_wb_pending got %h exp 200", pending); end
    checks++; if (read_data2 !== 64'h2020) begin errors++; $display("FAIL nonpend_wb_data got %h exp 2020", read_data2); end
    reg_write = 1; write_reg = 9; write_data = 64'h0; tick(); idle(); #1;
  endtask

  task automatic test_reset_midflight();
    idle(); issue_valid = 1; issue_rd = 4; tick();
    issue_rd = 12; tick(); idle(); #1;
    checks++; if (pending !== 32'h0000_1010) begin errors++; $display("FAIL mid_pending got %h exp 1010", pending); end
    reset_n = 0; issue_valid = 1; issue_rd = 4; rs1 = 4; rs1_used = 1;
    reg_write = 1; write_reg = 6; write_data = 64'h66; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall_in_reset got %b exp 0", stall); end
    tick(); reset_n = 1; idle(); rs2 = 6; #1;
    checks++; if (pending !== '0) begin errors++; $display("FAIL mid_pending_cleared got %h exp 0", pending); end
    checks++; if (read_data2 !== '0) begin errors++; $display("FAIL mid_write_ignored got %h exp 0", read_data2); end
    issue_valid = 1; issue_rd = 2; rs1 = 4; rs1_used = 1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_no_stall got %b exp 0", stall); end
    tick(); idle(); #1;
    checks++; if (pending !== 32'h0000_0004) begin errors++; $display("FAIL mid_reissue got %h exp 4", pending); end
  endtask

  initial begin
    reset_n = 0;
    idle();
    test_reset();
    test_x0();
    test_bypass();
    test_raw();
    test_waw();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
